ring_decode_monitor: RTL

//  Receive-side companion to the 8-bit one-hot ring counter.

---
 rtl/ring_pkg.sv | 17 +
 rtl/ring_decode_monitor_onehot.sv | 30 +++
 rtl/ring_decode_monitor.sv | 114 +++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the ring code decoder/monitor
package ring_pkg;

  localparam int RING_WIDTH = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Position that a correctly advancing ring reaches after idx.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ring_decode_monitor_onehot.sv
// rtl/ring_decode_monitor_onehot.sv - one-hot ring code to binary index with legality flag
module onehot_to_index
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_in,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  // idx ends on the highest set bit; only meaningful when legal.
  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        cnt = cnt + CNT_W'(1);
        idx = IDX_W'(i);
      end
    end
    legal = (cnt == CNT_W'(1));
  end

endmodule

// File: rtl/ring_decode_monitor.sv
// rtl/ring_decode_monitor.sv - decodes a sampled ring code and tracks lock, laps and sequence errors
module ring_decode_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH    = RING_WIDTH,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int LOCK_CNT = 2,
  parameter int LAP_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             in_valid,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             locked,
  output logic             seq_err,
  output logic [LAP_W-1:0] lap_count,
  output logic [7:0]       err_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  state_t           state;
  logic [RUN_W-1:0] run;
  logic [IDX_W-1:0] last_idx;
  logic             legal;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt;
  logic [RUN_W-1:0] run_inc;

  onehot_to_index #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .ring_in (ring_in),
    .legal   (legal),
    .idx     (idx)
  );

  assign nxt     = IDX_W'(next_idx(32'(last_idx), WIDTH));
  assign run_inc = run + RUN_W'(1);
  // last_idx only moves on legal samples, which is exactly what index must show.
  assign index   = last_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      run         <= '0;
      last_idx    <= '0;
      index_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      lap_count   <= '0;
      err_count   <= '0;
    end else begin
      seq_err <= 1'b0;
      if (in_valid) begin
        index_valid <= legal;
        if (legal) begin
          last_idx <= idx;
        end
        case (state)
          HUNT: begin
            if (legal) begin
              state <= TRACK;
              run   <= '0;
            end
          end
          TRACK: begin
            if (!legal) begin
              state <= HUNT;
            end else if (idx == nxt && idx != last_idx) begin
              run <= run_inc;
              if (run_inc == RUN_W'(LOCK_CNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (idx != last_idx) begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (legal && idx == last_idx) begin
              state <= LOCKED;
            end else if (legal && idx == nxt) begin
              if (idx == '0) begin
                lap_count <= lap_count + LAP_W'(1);
              end
            end else begin
              // Any other sample breaks the lock; a legal one seeds a new track.
              seq_err <= 1'b1;
              locked  <= 1'b0;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
              if (legal) begin
                state <= TRACK;
                run   <= '0;
              end else begin
                state <= HUNT;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
